// File: rtl/lvds_rx_iq_unpack_if.sv
// Frame input and unpacked-sample output bundle of the LVDS I/Q unpacker.
// The slave side is the unpacker; the master side is its environment.
interface lvds_rx_iq_unpack_if #(
    parameter int unsigned OUT_W = 16
);
    logic             i_valid;
    logic [31:0]      i_data;
    logic             i_ready;
    logic             o_valid;
    logic [OUT_W-1:0] o_i;
    logic [OUT_W-1:0] o_q;
    logic [1:0]       o_ctrl;

    modport slave (
        input  i_valid, i_data, i_ready,
        output o_valid, o_i, o_q, o_ctrl
    );

    modport master (
        output i_valid, i_data, i_ready,
        input  o_valid, o_i, o_q, o_ctrl
    );
endinterface

// File: rtl/lvds_rx_iq_unpack.sv
// Sync-checks 32-bit LVDS I/Q frames and unpacks them into a show-ahead FIFO.
// Saturating counters track sync-error drops and FIFO-full drops.
module lvds_rx_iq_unpack #(
    parameter int unsigned FIFO_AW = 2,
    parameter int unsigned OUT_W   = 16,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                i_ddr_clk,
    input  logic                i_reset,
    input  logic                i_rx_en,
    lvds_rx_iq_unpack_if.slave  bus,
    output logic [FIFO_AW:0]    o_level,
    input  logic                i_cnt_clear,
    output logic [CNT_W-1:0]    o_ovf_cnt,
    output logic [CNT_W-1:0]    o_sync_err_cnt
);
    localparam int unsigned DEPTH = 2 ** FIFO_AW;
    localparam int unsigned SMP_W = 13;
    localparam int unsigned ENT_W = 2 * SMP_W + 2;
    localparam int unsigned LVL_W = FIFO_AW + 1;

    logic               stg_valid_q, stg_valid_d;
    logic [31:0]        stg_data_q, stg_data_d;
    logic [ENT_W-1:0]   mem_q [DEPTH];
    logic [ENT_W-1:0]   mem_d [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic               valid_q, valid_d;
    logic [OUT_W-1:0]   i_smp_q, i_smp_d;
    logic [OUT_W-1:0]   q_smp_q, q_smp_d;
    logic [1:0]         ctrl_q, ctrl_d;
    logic [CNT_W-1:0]   ovf_q, ovf_d;
    logic [CNT_W-1:0]   serr_q, serr_d;

    logic               sync_ok_c;
    logic               pop_c;
    logic               wr_ok_c;
    logic               push_c;
    logic [ENT_W-1:0]   entry_c;
    logic [ENT_W-1:0]   head_c;

    // Next-state: stage capture, FIFO push/pop, registered head view, counters.
    always_comb begin
        stg_valid_d = 1'b0;
        stg_data_d  = stg_data_q;
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        ovf_d       = ovf_q;
        serr_d      = serr_q;

        sync_ok_c = (stg_data_q[31:30] == 2'b10) && (stg_data_q[15:14] == 2'b01);
        pop_c     = valid_q & bus.i_ready;
        wr_ok_c   = (level_q < LVL_W'(DEPTH)) | pop_c;
        push_c    = stg_valid_q & sync_ok_c & wr_ok_c;
        entry_c   = {stg_data_q[29:17], stg_data_q[13:1], stg_data_q[16], stg_data_q[0]};

        if (bus.i_valid && i_rx_en) begin
            stg_valid_d = 1'b1;
            stg_data_d  = bus.i_data;
        end

        if (push_c) begin
            mem_d[wr_ptr_q] = entry_c;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        level_d = level_q + LVL_W'(push_c) - LVL_W'(pop_c);
        valid_d = (level_d != '0);

        // Head is sampled from next-state memory so a write into an empty FIFO shows after one edge.
        head_c  = mem_d[rd_ptr_d];
        i_smp_d = OUT_W'($signed(head_c[ENT_W-1 -: SMP_W]));
        q_smp_d = OUT_W'($signed(head_c[ENT_W-1-SMP_W -: SMP_W]));
        ctrl_d  = head_c[1:0];

        if (i_cnt_clear) begin
            ovf_d  = '0;
            serr_d = '0;
        end else if (stg_valid_q) begin
            if (!sync_ok_c && (serr_q != '1)) begin
                serr_d = serr_q + CNT_W'(1);
            end
            if (sync_ok_c && !wr_ok_c && (ovf_q != '1)) begin
                ovf_d = ovf_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge i_ddr_clk) begin
        if (i_reset) begin
            stg_valid_q <= 1'b0;
            stg_data_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            valid_q  <= 1'b0;
            i_smp_q  <= '0;
            q_smp_q  <= '0;
            ctrl_q   <= '0;
            ovf_q    <= '0;
            serr_q   <= '0;
        end else begin
            stg_valid_q <= stg_valid_d;
            stg_data_q  <= stg_data_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            valid_q     <= valid_d;
            i_smp_q     <= i_smp_d;
            q_smp_q     <= q_smp_d;
            ctrl_q      <= ctrl_d;
            ovf_q       <= ovf_d;
            serr_q      <= serr_d;
        end
    end

    assign bus.o_valid     = valid_q;
    assign bus.o_i         = i_smp_q;
    assign bus.o_q         = q_smp_q;
    assign bus.o_ctrl      = ctrl_q;
    assign o_level         = level_q;
    assign o_ovf_cnt       = ovf_q;
    assign o_sync_err_cnt  = serr_q;
endmodule

// File: doc/lvds_rx_iq_unpack.md
Name: lvds_rx_iq_unpack

Overview:
Downstream of the LVDS DDR deserializer, in the i_ddr_clk domain. Consumes each assembled 32-bit modem I/Q frame and checks both sync symbols. Unpacks the 13-bit signed I and Q samples plus their control bits, sign-extends the samples, and buffers them in a small show-ahead FIFO with a valid/ready output handshake. Keeps saturating counters for overflow drops and sync errors, for status readout by the host.

Parameters:
FIFO_AW, 2, FIFO address width; depth = 2**FIFO_AW entries.
OUT_W, 16, output sample width; 13-bit samples sign-extended to OUT_W (OUT_W >= 13).
CNT_W, 16, width of the error/drop counters.

Ports:
i_ddr_clk  in  1  clock.
i_reset  in  1  synchronous, active-high reset.
i_rx_en  in  1  frame acceptance enable; 0 = ignore all input frames, no counting.
i_valid  in  1  frame strobe from deserializer, one cycle per frame.
i_data  in  32  frame, layout [31:30]=I sync 2'b10, [29:17]=I[12:0], [16]=I ctrl, [15:14]=Q sync 2'b01, [13:1]=Q[12:0], [0]=Q ctrl.
i_ready  in  1  downstream ready.
o_valid  out  1  FIFO head valid (= not empty).
o_i  out  OUT_W  sign-extended I of head entry.
o_q  out  OUT_W  sign-extended Q of head entry.
o_ctrl  out  2  {I ctrl, Q ctrl} of head entry.
o_level  out  FIFO_AW+1  current FIFO occupancy, 0..2**FIFO_AW.
i_cnt_clear  in  1  single-cycle clear of both counters.
o_ovf_cnt  out  CNT_W  frames dropped because FIFO full, saturating.
o_sync_err_cnt  out  CNT_W  frames dropped for bad sync bits, saturating.

Behaviour:
- Reset (i_reset=1 at clock edge): FIFO empty, pointers 0, o_valid=0, o_level=0, o_i/o_q/o_ctrl=0, both counters 0, stage register invalid. Reset mid-operation discards all buffered and in-flight frames.
- Stage 1 (input register): on i_valid & i_rx_en, capture i_data, mark stage valid.
  - Sync check: I sync == 2'b10 and Q sync == 2'b01.
  - Sign extension: replicate bit 12 of each sample into the upper OUT_W-13 bits.
- Stage 2 (FIFO write), from the valid stage register:
  - Sync bad: drop the frame; o_sync_err_cnt +1.
  - Sync good and write permitted: push {I, Q, ctrl}.
  - Sync good, write not permitted: drop the frame; o_ovf_cnt +1.
  - Write permitted = level < depth, OR a pop occurs in the same cycle.
- Latency: i_valid sampled at edge N; entry written at edge N+1. With an empty FIFO, o_valid=1 and data on the outputs after edge N+1.
- Output handshake:
  - Pop occurs on an edge with o_valid & i_ready.
  - o_i/o_q/o_ctrl always reflect the head entry (show-ahead) and are stable while o_valid & !i_ready.
  - o_valid drops the cycle after the last entry pops, unless a write lands on that same edge.
- Simultaneous push and pop:
  - Level unchanged.
  - Empty FIFO: the written entry appears at the head after the edge; there is no bypass into the current cycle.
- Pointers: wrap modulo depth. o_level is the registered occupancy.
- Back-to-back i_valid on consecutive cycles: every frame is processed, one per cycle.
- Counters:
  - Saturate at all-ones.
  - i_cnt_clear zeroes both; clear wins over a coincident increment.
  - Counters are not cleared by i_rx_en.
- i_rx_en deasserted: frames already in stage 1 complete. FIFO contents remain readable.

Test Plan:
- Reset, then i_data=32'h9FFE6001 with i_valid 1 cycle -> 2 edges later o_valid=1, o_i=16'h0FFF, o_q=16'hF000, o_ctrl=2'b01; pop with i_ready=1 -> o_valid=0 next cycle, o_level=0.
- Bad sync: i_data=32'h1FFE6001 (I sync 2'b00) -> no write, o_valid stays 0, o_sync_err_cnt=1, o_ovf_cnt=0.
- Overflow: i_ready=0, 6 valid frames back-to-back, depth 4 -> o_level=4, o_ovf_cnt=2; then pop 4 -> first 4 frames emerge in order.
- Full FIFO with i_ready=1 and a new frame arriving on the pop edge -> frame accepted, o_level stays 4, o_ovf_cnt unchanged.
- Counter saturation: CNT_W=4, 17 bad-sync frames -> o_sync_err_cnt=4'hF; i_cnt_clear pulsed together with an 18th bad frame -> counter=0.
- Reset mid-stream: 3 entries buffered, plus one frame in stage 1 -> assert i_reset one cycle -> o_valid=0, o_level=0, counters=0, in-flight frame never appears.
